// File: rtl/pipe_regwall_if.sv
// Handshake bundle for pipe_regwall: producer side (in_*) and consumer side (out_*).
// The design connects through the slave modport; the surrounding logic uses master.
interface pipe_regwall_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipe_regwall.sv
// pipe_regwall: linear register pipeline with per-stage stall and flush.
// Each stage carries valid, payload and a sequence tag stamped at entry.
// A hold in any stage freezes it and every younger stage; the stage just
// older than a hold fills with a bubble. Bubbles are never squeezed out.
module pipe_regwall #(
  parameter  int DATA_W        = 32,
  parameter  int STAGES        = 4,
  parameter  int TAG_W         = 4,
  parameter  int FLUSH_YOUNGER = 0,
  localparam int OCC_W         = $clog2(STAGES + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  pipe_regwall_if.slave            bus,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic [OCC_W-1:0]         occupancy
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  logic [TAG_W-1:0]  seq_q, seq_d;

  logic [STAGES-1:0] hold_eff;
  logic [STAGES-1:0] flush_eff;
  logic              last_hold;
  logic              accept;

  // Hold propagates from the oldest stage toward stage 0; flush may widen toward younger stages.
  always_comb begin
    last_hold = stall[STAGES-1] | (valid_q[STAGES-1] & ~bus.out_ready);
    for (int k = 0; k < STAGES; k++) begin
      logic h;
      logic f;
      h = last_hold;
      f = 1'b0;
      for (int m = k; m < STAGES; m++) begin
        h = h | stall[m];
        if (m == k || FLUSH_YOUNGER != 0) f = f | flush[m];
      end
      hold_eff[k]  = h;
      flush_eff[k] = f;
    end
  end

  // Next-state for every stage and the sequence counter.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable; otherwise a latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    accept  = bus.in_valid & ~hold_eff[0];
    seq_d   = seq_q + TAG_W'(accept);

    if (flush_eff[0]) begin
      valid_d[0] = 1'b0;
      data_d[0]  = '0;
      tag_d[0]   = '0;
    end else if (!hold_eff[0]) begin
      valid_d[0] = bus.in_valid;
      data_d[0]  = bus.in_valid ? bus.in_data : '0;
      tag_d[0]   = bus.in_valid ? seq_q : '0;
    end

    for (int k = 1; k < STAGES; k++) begin
      if (flush_eff[k] || (!hold_eff[k] && hold_eff[k-1])) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
        tag_d[k]   = '0;
      end else if (!hold_eff[k]) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
        tag_d[k]   = tag_q[k-1];
      end
    end
  end

  // State registers with synchronous active-low reset; pipeline contents are cleared so reset drops in-flight items.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      valid_q <= '0;
      seq_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      seq_q   <= seq_d;
    end
  end

  // Observation outputs: per-stage view and popcount of valid stages.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_data[k*DATA_W +: DATA_W] = data_q[k];
      occupancy = occupancy + OCC_W'(valid_q[k]);
    end
  end

  assign stage_valid   = valid_q;
  assign bus.in_ready  = ~hold_eff[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];
  assign bus.out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_pipe_regwall.sv
// Bench for pipe_regwall: a table of per-cycle vectors plus hand-written
// sequences for reset, backpressure and flush. Output payload/tag order is
// checked against a scoreboard queue filled at acceptance.
module tb_pipe_regwall;
  localparam int DW = 8;
  localparam int ST = 4;
  localparam int TW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic [ST-1:0] stall, flush;

  logic [ST-1:0]    sv0, sv1;
  logic [ST*DW-1:0] sd0, sd1;
  logic [2:0]       occ0, occ1;

  pipe_regwall_if #(.DATA_W(DW), .TAG_W(TW)) bus0 ();
  pipe_regwall_if #(.DATA_W(DW), .TAG_W(TW)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;

  pipe_regwall #(.DATA_W(DW), .STAGES(ST), .TAG_W(TW), .FLUSH_YOUNGER(0)) dut0 (
    .clock(clk), .reset_n(rst_n), .bus(bus0), .stall(stall), .flush(flush),
    .stage_valid(sv0), .stage_data(sd0), .occupancy(occ0)
  );

  pipe_regwall #(.DATA_W(DW), .STAGES(ST), .TAG_W(TW), .FLUSH_YOUNGER(1)) dut1 (
    .clock(clk), .reset_n(rst_n), .bus(bus1), .stall(stall), .flush(flush),
    .stage_valid(sv1), .stage_data(sd1), .occupancy(occ1)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } item_t;

  item_t         sb[$];
  logic [TW-1:0] seq_m;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [ST-1:0] st;
    logic          ordy;
    logic          e_rdy;
    int            e_occ;
    logic          e_ov;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: score output transfer and record acceptance, then advance to the next negedge.
  task automatic tick();
    if (rst_n && bus0.out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        item_t e;
        e = sb.pop_front();
        check("out_data", 32'(bus0.out_data), 32'(e.data));
        check("out_tag",  32'(bus0.out_tag),  32'(e.tag));
      end
    end
    if (rst_n && in_valid && bus0.in_ready) begin
      sb.push_back('{data: in_data, tag: seq_m});
      seq_m = seq_m + TW'(1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stall     = '0;
    flush     = '0;
    for (int n = 0; n < 20 && sb.size() != 0; n++) begin
      #1;
      tick();
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  function automatic void add(input logic iv, input logic [DW-1:0] d, input logic [ST-1:0] st,
                              input logic ordy, input logic rdy, input int occ, input logic ov);
    vecs.push_back('{iv, d, st, ordy, rdy, occ, ov});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    stall = '0; flush = '0; seq_m = '0;

    // stream 0x11..0x55: first output after 4 edges, then one per cycle
    add(1, 8'h11, 4'b0000, 1, 1, 0, 0);
    add(1, 8'h22, 4'b0000, 1, 1, 1, 0);
    add(1, 8'h33, 4'b0000, 1, 1, 2, 0);
    add(1, 8'h44, 4'b0000, 1, 1, 3, 0);
    add(1, 8'h55, 4'b0000, 1, 1, 4, 1);
    add(0, 8'h00, 4'b0000, 1, 1, 4, 1);
    add(0, 8'h00, 4'b0000, 1, 1, 3, 1);
    add(0, 8'h00, 4'b0000, 1, 1, 2, 1);
    add(0, 8'h00, 4'b0000, 1, 1, 1, 1);
    add(0, 8'h00, 4'b0000, 1, 1, 0, 0);
    // fill, then stall stage 1 for two cycles
    add(1, 8'hA0, 4'b0000, 1, 1, 0, 0);
    add(1, 8'hA1, 4'b0000, 1, 1, 1, 0);
    add(1, 8'hA2, 4'b0000, 1, 1, 2, 0);
    add(1, 8'hA3, 4'b0000, 1, 1, 3, 0);
    add(1, 8'hA4, 4'b0010, 1, 0, 4, 1);
    add(1, 8'hA4, 4'b0010, 1, 0, 3, 1);
    add(1, 8'hA4, 4'b0000, 1, 1, 2, 0);
    add(0, 8'h00, 4'b0000, 1, 1, 3, 0);
    add(0, 8'h00, 4'b0000, 1, 1, 3, 1);
    add(0, 8'h00, 4'b0000, 1, 1, 2, 1);
    add(0, 8'h00, 4'b0000, 1, 1, 1, 1);
    add(0, 8'h00, 4'b0000, 1, 1, 0, 0);

    // reset state, with in_ready still combinational during reset
    repeat (2) @(negedge clk);
    #1;
    check("rst_occ",       32'(occ0), 32'd0);
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_stage_vld", 32'(sv0), 32'd0);
    check("rst_in_ready",  32'(bus0.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].d; stall = vecs[i].st;
      flush = '0; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("row%0d.in_ready", i),  32'(bus0.in_ready),  32'(vecs[i].e_rdy));
      check($sformatf("row%0d.occ", i),       32'(occ0),           32'(vecs[i].e_occ));
      check($sformatf("row%0d.out_valid", i), 32'(bus0.out_valid), 32'(vecs[i].e_ov));
      tick();
    end
    check("table_sb_empty", 32'(sb.size()), 32'd0);

    // reset mid-stream with three items in flight
    stall = '0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hD0 + 8'(i);
      #1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("rstmid_pre_occ", 32'(occ0), 32'd3);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    #1;
    tick();
    check("rstmid_occ",       32'(occ0), 32'd0);
    check("rstmid_out_valid", 32'(bus0.out_valid), 32'd0);
    sb.delete();
    seq_m = '0;
    rst_n = 1'b1;

    // backpressure: full pipe freezes, then 5 accepts carry tags 0,1,2,3,0
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hB0 + 8'(i);
      #1;
      if (i == 0) check("bp_first_rdy", 32'(bus0.in_ready), 32'd1);
      tick();
    end
    in_data = 8'hB4;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(bus0.in_ready), 32'd0);
      check("bp_occ",      32'(occ0), 32'd4);
      check("bp_out_data", 32'(bus0.out_data), 32'hB0);
      check("bp_out_tag",  32'(bus0.out_tag), 32'd0);
      tick();
    end
    check("bp_stage_vld", 32'(sv0), 32'hF);
    out_ready = 1'b1;
    #1;
    tick();
    check("bp_wrap_tag", 32'(sd0[DW-1:0]), 32'hB4);
    drain();

    // flush stage 2 of a full, frozen pipe
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hC0 + 8'(i);
      #1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("fl_pre_occ0", 32'(occ0), 32'd4);
    check("fl_pre_occ1", 32'(occ1), 32'd4);
    flush = 4'b0100;
    #1;
    tick();
    flush = '0;
    sb.delete(1);
    #1;
    check("fl_occ0",      32'(occ0), 32'd3);
    check("fl_stg_vld0",  32'(sv0), 32'b1011);
    check("fl_stg2_data", 32'(sd0[2*DW +: DW]), 32'd0);
    check("fl_occ1",      32'(occ1), 32'd1);
    check("fl_stg_vld1",  32'(sv1), 32'b1000);

    // flush and stall on the last stage together
    stall = 4'b1000; flush = 4'b1000;
    #1;
    check("fs_in_ready", 32'(bus0.in_ready), 32'd0);
    tick();
    stall = '0; flush = '0;
    sb.delete(0);
    #1;
    check("fs_stg_vld", 32'(sv0), 32'b0011);
    check("fs_occ",     32'(occ0), 32'd2);
    check("fs_stg1",    32'(sd0[DW +: DW]), 32'hC2);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
